// File: rtl/round_timer_pkg.sv
// round_timer_pkg: shared state encoding and default sizing for the round timer
package round_timer_pkg;
    localparam int SEC_W = 5;
    localparam int DEF_ROUND_SECS = 30;
    localparam int DEF_NUM_ROUNDS = 3;
    typedef enum logic [2:0] {IDLE, RUN, PAUSE, ROUND_END, GAME_OVER} state_t;
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle second tick while enabled
module sec_prescaler #(
    parameter int CLK_HZ = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(CLK_HZ - 1);
    always_ff @(posedge clk)
        if (!reset || clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: game-round sequencer with countdown, pause, scoring and game over
import round_timer_pkg::*;
module round_timer_ctrl #(
    parameter int CLK_HZ = 100_000_000,
    parameter int ROUND_SECS = DEF_ROUND_SECS,
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               answer_valid,
    input  logic               answer_correct,
    output logic [SEC_W-1:0]   secs_left,
    output logic [1:0]         round_idx,
    output logic [SCORE_W-1:0] score,
    output logic               timer_active,
    output logic               timeout_pulse,
    output logic               game_over
);
    state_t state, state_nx;
    logic tick, go, expire, last, next_round;
    assign timer_active = state == RUN;
    assign game_over = state == GAME_OVER;
    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
        .clk(clk), .reset(reset), .en(timer_active),
        .clr(!(state == RUN || state == PAUSE)), .tick(tick)
    );
    always_comb begin
        go = start && (state == IDLE || state == GAME_OVER);
        last = round_idx == 2'(NUM_ROUNDS - 1);
        next_round = state == ROUND_END && !last;
        expire = timer_active && tick && secs_left <= SEC_W'(1) && !answer_valid;
        state_nx = state;
        case (state)
            IDLE, GAME_OVER: state_nx = start ? RUN : state;
            RUN:             state_nx = (answer_valid || expire) ? ROUND_END : pause ? PAUSE : RUN;
            PAUSE:           state_nx = pause ? RUN : PAUSE;
            ROUND_END:       state_nx = last ? GAME_OVER : RUN;
            default:         state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_nx;
    always_ff @(posedge clk)
        if (!reset || go || next_round) secs_left <= SEC_W'(ROUND_SECS);
        else if (tick) secs_left <= secs_left == '0 ? '0 : secs_left - 1'b1;
    always_ff @(posedge clk)
        if (!reset || go) round_idx <= '0;
        else if (next_round) round_idx <= round_idx + 1'b1;
    always_ff @(posedge clk)
        if (!reset || go) score <= '0;
        else if (timer_active && answer_valid && answer_correct && score != {SCORE_W{1'b1}})
            score <= score + 1'b1;
    always_ff @(posedge clk)
        timeout_pulse <= reset && expire;
endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb_round_timer_ctrl: directed vector table plus a full-game timeout sequence
module tb_round_timer_ctrl;
    logic clk = 0, reset = 0, start = 0, pause = 0, answer_valid = 0, answer_correct = 0;
    logic [4:0] secs_left;
    logic [1:0] round_idx;
    logic [7:0] score;
    logic timer_active, timeout_pulse, game_over;
    int checks = 0, failures = 0;
    round_timer_ctrl #(.CLK_HZ(4), .ROUND_SECS(3), .NUM_ROUNDS(2), .SCORE_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .answer_valid(answer_valid), .answer_correct(answer_correct),
        .secs_left(secs_left), .round_idx(round_idx), .score(score),
        .timer_active(timer_active), .timeout_pulse(timeout_pulse), .game_over(game_over)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic rst_n, st, pa, av, ac;
        int extra;
        logic [4:0] secs;
        logic [1:0] rnd;
        logic [7:0] sc;
        logic act, to, go;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(logic rst_n, st, pa, av, ac, int extra,
                                logic [4:0] secs, logic [1:0] rnd, logic [7:0] sc, logic act, to, go);
        mk = '{rst_n, st, pa, av, ac, extra, secs, rnd, sc, act, to, go};
    endfunction
    task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL vec%0d %s got=%0d exp=%0d", idx, name, got, exp);
        end
    endtask
    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int n, pulses;
        //            rst st pa av ac ex  secs rnd sc act to go
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2,  3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  3, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 11, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0,  2, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0,  3, 1, 2, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  3, 1, 2, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 19, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2,  1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  3, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0,  3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0,  3, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  3, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  3, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  3, 1, 0, 1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst_n; start = tbl[i].st; pause = tbl[i].pa;
            answer_valid = tbl[i].av; answer_correct = tbl[i].ac;
            tick_edge();
            reset = 1; start = 0; pause = 0; answer_valid = 0; answer_correct = 0;
            repeat (tbl[i].extra) tick_edge();
            chk("secs_left", i, 32'(secs_left), 32'(tbl[i].secs));
            chk("round_idx", i, 32'(round_idx), 32'(tbl[i].rnd));
            chk("score", i, 32'(score), 32'(tbl[i].sc));
            chk("timer_active", i, 32'(timer_active), 32'(tbl[i].act));
            chk("timeout_pulse", i, 32'(timeout_pulse), 32'(tbl[i].to));
            chk("game_over", i, 32'(game_over), 32'(tbl[i].go));
        end
        reset = 0;
        tick_edge();
        reset = 1; start = 1;
        tick_edge();
        start = 0;
        n = 0; pulses = 0;
        while (!game_over && n < 100) begin
            tick_edge();
            n++;
            pulses += int'(timeout_pulse);
        end
        chk("full_game_cycles", 100, n, 26);
        chk("full_game_timeouts", 100, pulses, 2);
        chk("full_game_score", 100, 32'(score), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
